// File: rtl/ander_serial_unit.sv
// ander_serial_unit: bit-serial AND of two WIDTH-bit operands, MSB first, with the
// result word reassembled and held behind a valid/ready output port.
module ander_serial_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ser_valid,
  output logic             ser_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_sa, r_sb, r_acc;
  logic [CW-1:0]    r_cnt;
  logic             w_take;
  logic [WIDTH-1:0] w_acc;
  assign in_ready = (r_state == IDLE) | ((r_state == HOLD) & out_ready);
  assign busy     = r_state != IDLE;
  assign w_take   = in_ready & in_valid;
  assign w_acc    = {r_acc[WIDTH-2:0], ser_bit};
  // ser_bit always shows the bit being accumulated at the coming edge, so the
  // MSB is produced at capture time and the operand copies are stored pre-shifted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_sa      <= '0;
      r_sb      <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      ser_valid <= 1'b0;
      ser_bit   <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
    end else begin
      if (w_take) begin
        r_sa      <= a << 1;
        r_sb      <= b << 1;
        ser_bit   <= a[WIDTH-1] & b[WIDTH-1];
        ser_valid <= 1'b1;
        r_cnt     <= CW'(WIDTH - 1);
        r_state   <= SHIFT;
      end else if (r_state == HOLD && out_ready) begin
        r_state <= IDLE;
      end
      if (r_state == HOLD && out_ready) out_valid <= 1'b0;
      if (r_state == SHIFT) begin
        r_acc   <= w_acc;
        r_sa    <= r_sa << 1;
        r_sb    <= r_sb << 1;
        ser_bit <= r_sa[WIDTH-1] & r_sb[WIDTH-1];
        r_cnt   <= r_cnt - 1'b1;
        if (r_cnt == '0) begin
          result    <= w_acc;
          out_valid <= 1'b1;
          ser_valid <= 1'b0;
          r_state   <= HOLD;
        end
      end
    end
  end
endmodule

// File: tb/tb_ander_serial_unit.sv
// tb_ander_serial_unit: cycle-level transaction model plus directed and exhaustive
// vectors for the bit-serial AND unit at WIDTH=4.
module tb_ander_serial_unit;
  localparam int W = 4;
  logic clk = 1'b0;
  logic reset, in_valid, out_ready;
  logic [W-1:0] a, b;
  logic in_ready, ser_valid, ser_bit, out_valid, busy;
  logic [W-1:0] result;
  int n_tests = 0, n_fail = 0;
  bit chk_en = 0, rnd = 0;
  always #5 clk = ~clk;
  ander_serial_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ser_valid(ser_valid), .ser_bit(ser_bit),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Transaction model: an accepted pair occupies W serial cycles then holds a&b until taken.
  bit m_active = 0, m_hold = 0;
  int m_k = 0;
  logic [W-1:0] m_word = '0, m_result = '0;
  always @(posedge clk) begin
    if (reset) begin
      m_active = 0; m_hold = 0; m_k = 0; m_result = '0;
    end else if (!m_active || (m_hold && out_ready)) begin
      m_active = 0; m_hold = 0;
      if (in_valid) begin
        m_active = 1; m_k = 1; m_word = a & b;
      end
    end else if (!m_hold) begin
      if (m_k == W) begin
        m_hold = 1; m_result = m_word;
      end else m_k++;
    end
  end
  logic [W-1:0] sacc = '0;
  logic pov = 0;
  int n_hs = 0;
  always @(negedge clk) if (chk_en) begin
    chk("in_ready", in_ready, !m_active || (m_hold && out_ready));
    chk("busy", busy, m_active);
    chk("ser_valid", ser_valid, m_active && !m_hold);
    chk("out_valid", out_valid, m_hold);
    chk("result", result, m_result);
    if (m_active && !m_hold) chk("ser_bit", ser_bit, m_word[W-m_k]);
    if (ser_valid) sacc = {sacc[W-2:0], ser_bit};
    if (out_valid && !pov) chk("stream_vs_result", result, sacc);
    if (out_valid && out_ready) n_hs++;
    pov = out_valid;
  end
  task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb);
    bit ok;
    in_valid = 1; a = va; b = vb;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk) ok = in_ready;
      @(posedge clk); #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      if (ok) begin
        in_valid = 0;
        return;
      end
    end
    in_valid = 0;
    chk("send_timeout", 0, 1);
  endtask
  initial begin
    logic [W-1:0] pat;
    bit got;
    reset = 1; in_valid = 0; out_ready = 0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 reset = 0; chk_en = 1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_busy", busy, 0);
    // basic
    @(posedge clk); #1 out_ready = 1;
    send(4'b1011, 4'b1110);
    pat = 4'b1010;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      chk("basic_ser_valid", ser_valid, 1);
      chk("basic_ser_bit", ser_bit, pat[W-1-k]);
    end
    @(negedge clk);
    chk("basic_out_valid", out_valid, 1);
    chk("basic_result", result, 4'b1010);
    @(negedge clk);
    chk("basic_idle", busy, 0);
    // backpressure
    @(posedge clk); #1 out_ready = 0;
    send(4'hF, 4'h9);
    repeat (W) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_result", result, 4'h9);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_out_dropped", out_valid, 0);
    chk("bp_idle", busy, 0);
    // back-to-back
    send(4'hC, 4'hA);
    repeat (W) @(posedge clk);
    #1 in_valid = 1; a = 4'h5; b = 4'h7;
    @(negedge clk);
    chk("b2b_first", result, 4'h8);
    chk("b2b_in_ready", in_ready, 1);
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    chk("b2b_no_idle", busy, 1);
    chk("b2b_restart", ser_valid, 1);
    repeat (W - 1) @(negedge clk);
    @(negedge clk);
    chk("b2b_second_valid", out_valid, 1);
    chk("b2b_second", result, 4'h5);
    // ignored input during SHIFT
    @(posedge clk); #1;
    send(4'hF, 4'hF);
    #1 in_valid = 1; a = 4'h0; b = 4'h0;
    @(posedge clk); #1 in_valid = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = out_valid;
    end
    chk("ign_done", got, 1);
    chk("ign_result", result, 4'hF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    // mid-operation reset
    send(4'hF, 4'hF);
    repeat (2) @(negedge clk);
    reset = 1;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("mr_ser_valid", ser_valid, 0);
    chk("mr_out_valid", out_valid, 0);
    chk("mr_result", result, 0);
    chk("mr_in_ready", in_ready, 1);
    chk("mr_busy", busy, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mr_no_out_valid", out_valid, 0);
    end
    // exhaustive with random stalls
    @(posedge clk); #1;
    n_hs = 0; rnd = 1;
    for (int i = 0; i < 256; i++) send(W'(i >> 4), W'(i));
    rnd = 0; out_ready = 1;
    repeat (W + 3) @(posedge clk);
    @(negedge clk);
    chk("exh_words", n_hs, 256);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ander_serial_unit.md
Name: ander_serial_unit

Overview:
- Bit-serial counterpart of the team's parallel 4-bit AND datapath.
- Accepts one pair of WIDTH-bit operands through a valid/ready handshake.
- ANDs the operands one bit per cycle, MSB first, and streams each result bit out.
- Reassembles the bits into a WIDTH-bit result word, presented on a valid/ready output port. Serves as the sequential, resource-shared alternative to one ander per bit.

Parameters:
WIDTH, 4, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  operands a/b valid.
in_ready  output  1  block can accept operands this cycle.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
ser_valid  output  1  ser_bit carries a valid result bit this cycle.
ser_bit  output  1  serial result bit, MSB first.
out_valid  output  1  result word complete and held.
out_ready  input  1  downstream accepts result.
result  output  WIDTH  reassembled word, equal to a AND b.
busy  output  1  high in SHIFT or HOLD.

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high; it is sampled only on the rising clk edge.
- Reset values:
  - state=IDLE, in_ready=1, ser_valid=0, ser_bit=0, out_valid=0, result=0, busy=0.
  - Internal shift registers and the bit counter clear to 0.
- FSM states: IDLE, SHIFT, HOLD.
- IDLE:
  - in_ready=1.
  - If in_valid=1 at the edge: capture a into sa and b into sb, set cnt=WIDTH-1, go to SHIFT.
- SHIFT (in_ready=0):
  - Each cycle drive ser_valid=1 and ser_bit = sa[WIDTH-1] & sb[WIDTH-1] (registered outputs).
  - At the edge: shift sa and sb left by 1, zero-filled. Shift the bit into the accumulator at LSB: acc = {acc[WIDTH-2:0], bit}. Decrement cnt.
  - When cnt==0 at the edge: load result with the final acc value including that bit, set out_valid=1, go to HOLD.
  - Exactly WIDTH consecutive ser_valid cycles per operation, with no gaps.
- HOLD:
  - ser_valid=0.
  - result and out_valid stay stable until out_ready=1 at an edge.
  - in_ready = out_ready (combinational), so that back-to-back issue is possible.
  - Handshake with in_valid=0: out_valid drops, go to IDLE.
  - Handshake with in_valid=1 in the same cycle: capture new operands and go directly to SHIFT. out_valid drops the next cycle.
- Latency: operands accepted at edge T. Serial bits appear in cycles T+1..T+WIDTH. out_valid rises at T+WIDTH+1.
  - Throughput with out_ready held high: one word every WIDTH+1 cycles.
- result register:
  - Retains its last value after the handshake until the next completed word overwrites it.
  - Consumers must qualify result with out_valid.
- Bit ordering: bit WIDTH-1 is emitted first and ends at result[WIDTH-1]. Bit 0 is emitted last and ends at result[0].
- Ignored inputs:
  - in_valid is ignored whenever in_ready=0; operands are not buffered.
  - a/b changing during SHIFT has no effect.
- Reset mid-operation: asserting reset in any state aborts the operation at the next edge and restores all reset values. The partial word is discarded and no out_valid is produced.
- out_ready outside HOLD has no effect.

Test Plan:
- Basic, WIDTH=4: a=4'b1011, b=4'b1110, in_valid for one cycle, out_ready=1 -> ser_bit sequence 1,0,1,0 with ser_valid high for exactly 4 cycles; out_valid at T+5; result=4'b1010.
- Backpressure: a=4'hF, b=4'h9, out_ready=0 for 10 cycles, then 1 -> result=4'h9 held stable with out_valid=1 and in_ready=0 until the handshake; then IDLE.
- Back-to-back:
  - First pair a=4'hC, b=4'hA; second pair a=4'h5, b=4'h7, presented in the HOLD cycle with out_ready=1.
  - Required: first result=4'h8; SHIFT restarts immediately; second result=4'h5; no IDLE cycle between the two words.
- Ignored input: during SHIFT, pulse in_valid with a=4'h0, b=4'h0 -> no effect; the in-flight result is unchanged (a=4'hF, b=4'hF gives 4'hF).
- Mid-operation reset: assert reset after 2 serial bits of a=4'hF, b=4'hF -> next cycle all outputs are at reset values, no out_valid pulse, and in_ready=1.
- Exhaustive: all 256 a/b pairs at WIDTH=4 with random out_ready stalls -> every result equals a&b, and the serial stream matches result MSB-first.
